// File: rtl/qei_input_filter.sv
// qei_input_filter: conditions raw quadrature encoder pads for the counter.
// Each phase signal passes through a 2-FF synchronizer and a programmable
// glitch filter. Channels whose A and B outputs change on the same edge are
// reported through sticky flags and a saturating 16-bit event counter.

// Single-signal synchronizer plus glitch filter.
// The output follows the synchronized input once the input has differed from
// the output for more than 'thresh' consecutive cycles.
module qei_sig_filter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             pad,
  input  logic [CNT_W-1:0] thresh,
  output logic             out
);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Synchronize the pad, then qualify changes against the live threshold.
  // cnt only advances while below thresh, so it can never wrap.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      out <= 1'b0;
    end else begin
      s1 <= pad;
      s2 <= s1;
      if (s2 == out) begin
        cnt <= '0;
      end else if (cnt >= thresh) begin
        out <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// Top level: per-channel filtering plus illegal-transition bookkeeping.
module qei_input_filter #(
  parameter int unsigned CH_NUM = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic [31:0]       FILT_CFG_Set,
  input  logic [31:0]       ERR_CLEAR_Set,
  input  logic [CH_NUM-1:0] PHASEA_in,
  input  logic [CH_NUM-1:0] PHASEB_in,
  output logic [CH_NUM-1:0] PHASEA_out,
  output logic [CH_NUM-1:0] PHASEB_out,
  output logic [31:0]       ERR_Read
);

  logic [CNT_W-1:0]  thresh;
  logic [CH_NUM-1:0] a_prev;
  logic [CH_NUM-1:0] b_prev;
  logic [CH_NUM-1:0] illegal;
  logic [CH_NUM-1:0] flags;
  logic [CH_NUM-1:0] flags_next;
  logic [4:0]        inc;
  logic [16:0]       cnt_sum;
  logic [15:0]       err_cnt;
  logic [15:0]       err_cnt_next;
  logic [31:0]       err_read_next;
  logic              unused_bits;

  assign thresh = FILT_CFG_Set[CNT_W-1:0];

  // Configuration bits outside the threshold and clear fields are don't-care.
  assign unused_bits = ^{FILT_CFG_Set[31:CNT_W], ERR_CLEAR_Set[30:CH_NUM]};

  for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_ch
    qei_sig_filter #(.CNT_W(CNT_W)) u_filt_a (
      .CLK    (CLK),
      .RST_n  (RST_n),
      .pad    (PHASEA_in[ch]),
      .thresh (thresh),
      .out    (PHASEA_out[ch])
    );

    qei_sig_filter #(.CNT_W(CNT_W)) u_filt_b (
      .CLK    (CLK),
      .RST_n  (RST_n),
      .pad    (PHASEB_in[ch]),
      .thresh (thresh),
      .out    (PHASEB_out[ch])
    );
  end

  // A channel is illegal when both filtered phases changed on the last edge.
  always_comb begin
    illegal = (PHASEA_out ^ a_prev) & (PHASEB_out ^ b_prev);
    inc     = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      inc = inc + {4'b0, illegal[i]};
    end
  end

  // Next flag/counter values: set beats clear, and a counter clear reloads
  // with this cycle's increment so simultaneous events are still counted.
  always_comb begin
    flags_next = (flags & ~ERR_CLEAR_Set[CH_NUM-1:0]) | illegal;
    cnt_sum    = {1'b0, err_cnt} + {12'b0, inc};
    if (ERR_CLEAR_Set[31]) begin
      err_cnt_next = {11'b0, inc};
    end else if (cnt_sum[16]) begin
      err_cnt_next = 16'hFFFF;
    end else begin
      err_cnt_next = cnt_sum[15:0];
    end
  end

  // Readback image of the current flags and counter.
  always_comb begin
    err_read_next               = '0;
    err_read_next[CH_NUM-1:0]   = flags;
    err_read_next[31:16]        = err_cnt;
  end

  // Phase history, error state and registered readback.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      a_prev   <= '0;
      b_prev   <= '0;
      flags    <= '0;
      err_cnt  <= '0;
      ERR_Read <= '0;
    end else begin
      a_prev   <= PHASEA_out;
      b_prev   <= PHASEB_out;
      flags    <= flags_next;
      err_cnt  <= err_cnt_next;
      ERR_Read <= err_read_next;
    end
  end

endmodule

// File: tb/tb_qei_input_filter.sv
// Directed bench for qei_input_filter: expectations are queued with the cycle
// they are due when stimulus is applied, and compared as that cycle arrives.
module tb_qei_input_filter;

  localparam int unsigned CH = 4;

  logic          CLK;
  logic          RST_n;
  logic [31:0]   FILT_CFG_Set;
  logic [31:0]   ERR_CLEAR_Set;
  logic [CH-1:0] PHASEA_in;
  logic [CH-1:0] PHASEB_in;
  logic [CH-1:0] PHASEA_out;
  logic [CH-1:0] PHASEB_out;
  logic [31:0]   ERR_Read;

  qei_input_filter #(.CH_NUM(CH), .CNT_W(8)) dut (
    .CLK           (CLK),
    .RST_n         (RST_n),
    .FILT_CFG_Set  (FILT_CFG_Set),
    .ERR_CLEAR_Set (ERR_CLEAR_Set),
    .PHASEA_in     (PHASEA_in),
    .PHASEB_in     (PHASEB_in),
    .PHASEA_out    (PHASEA_out),
    .PHASEB_out    (PHASEB_out),
    .ERR_Read      (ERR_Read)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned due;
    string       tag;
    int unsigned sel;   // 0: PHASEA_out, 1: PHASEB_out, 2: ERR_Read
    logic [31:0] mask;
    logic [31:0] exp;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc    = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [1:0]  qseq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  function automatic logic [31:0] observe(int unsigned sel);
    case (sel)
      0:       return {28'b0, PHASEA_out};
      1:       return {28'b0, PHASEB_out};
      default: return ERR_Read;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_at(int unsigned off, string tag, int unsigned sel,
                           logic [31:0] mask, logic [31:0] exp);
    exp_t e;
    e.due  = cyc + off;
    e.tag  = tag;
    e.sel  = sel;
    e.mask = mask;
    e.exp  = exp & mask;
    sbq.push_back(e);
  endtask

  task automatic run(int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      cyc++;
      for (int j = sbq.size() - 1; j >= 0; j--) begin
        if (sbq[j].due == cyc) begin
          check(sbq[j].tag, observe(sbq[j].sel) & sbq[j].mask, sbq[j].exp);
          sbq.delete(j);
        end
      end
    end
  endtask

  task automatic clear_errs();
    ERR_CLEAR_Set = '1;
    run(2);
    ERR_CLEAR_Set = '0;
    run(2);
  endtask

  initial begin
    RST_n         = 1'b0;
    FILT_CFG_Set  = '0;
    ERR_CLEAR_Set = '0;
    PHASEA_in     = '0;
    PHASEB_in     = '0;
    #1;
    check("reset_a",   {28'b0, PHASEA_out}, 32'h0);
    check("reset_b",   {28'b0, PHASEB_out}, 32'h0);
    check("reset_err", ERR_Read, 32'h0);
    run(2);
    RST_n = 1'b1;

    // Pads high after reset release, N=0: outputs rise on the 3rd edge.
    PHASEA_in = '1;
    PHASEB_in = '1;
    expect_at(2, "first_a_pre", 0, 32'hF, 32'h0);
    expect_at(3, "first_a",     0, 32'hF, 32'hF);
    expect_at(3, "first_b",     1, 32'hF, 32'hF);
    run(5);

    // Mid-cycle asynchronous reset pulse with pads held high.
    #2;
    RST_n = 1'b0;
    #1;
    check("midrst_a",   {28'b0, PHASEA_out}, 32'h0);
    check("midrst_b",   {28'b0, PHASEB_out}, 32'h0);
    check("midrst_err", ERR_Read, 32'h0);
    RST_n = 1'b1;
    expect_at(2, "rel_a_pre", 0, 32'hF, 32'h0);
    expect_at(3, "rel_a",     0, 32'hF, 32'hF);
    expect_at(3, "rel_b",     1, 32'hF, 32'hF);
    run(6);

    PHASEA_in = '0;
    PHASEB_in = '0;
    run(6);
    clear_errs();

    // Latency with N=5; upper config bits must not matter.
    FILT_CFG_Set = 32'hABCD_0005;
    PHASEA_in    = 4'b0001;
    expect_at(7, "lat_pre",   0, 32'h1, 32'h0);
    expect_at(8, "lat_a",     0, 32'hF, 32'h1);
    expect_at(8, "lat_b",     1, 32'hF, 32'h0);
    expect_at(8, "lat_err",   2, '1,    32'h0);
    run(12);

    // Glitch rejection with N=3: 3-cycle pulse dropped, 4-cycle passes.
    FILT_CFG_Set = 32'd3;
    for (int unsigned k = 1; k <= 12; k++) expect_at(k, "glitch3", 1, 32'h4, 32'h0);
    PHASEB_in = 4'b0100;
    run(3);
    PHASEB_in = '0;
    run(12);
    expect_at(5,  "pulse4_pre",  1, 32'h4, 32'h0);
    for (int unsigned k = 6; k <= 9; k++) expect_at(k, "pulse4_high", 1, 32'h4, 32'h4);
    expect_at(10, "pulse4_post", 1, 32'h4, 32'h0);
    PHASEB_in = 4'b0100;
    run(4);
    PHASEB_in = '0;
    run(10);

    // Quadrature sequence on channel 1, N=2: 5-cycle delay, no errors.
    FILT_CFG_Set = 32'd2;
    begin
      logic [1:0] prev;
      prev = 2'b00;
      for (int unsigned s = 0; s < 4; s++) begin
        PHASEA_in[1] = qseq[s][1];
        PHASEB_in[1] = qseq[s][0];
        expect_at(4,  "quad_a_old", 0, 32'h2, prev[1]    ? 32'h2 : 32'h0);
        expect_at(4,  "quad_b_old", 1, 32'h2, prev[0]    ? 32'h2 : 32'h0);
        expect_at(5,  "quad_a_new", 0, 32'h2, qseq[s][1] ? 32'h2 : 32'h0);
        expect_at(5,  "quad_b_new", 1, 32'h2, qseq[s][0] ? 32'h2 : 32'h0);
        expect_at(19, "quad_err",   2, '1, 32'h0);
        prev = qseq[s];
        run(20);
      end
    end

    // Illegal transitions, N=0.
    FILT_CFG_Set = 32'd0;
    PHASEA_in[3] = 1'b1;
    PHASEB_in[3] = 1'b1;
    expect_at(4, "ill3_pre", 2, '1, 32'h0);
    expect_at(5, "ill3",     2, '1, 32'h0001_0008);
    run(8);
    PHASEA_in[0] = 1'b0;
    PHASEB_in[0] = 1'b1;
    PHASEA_in[3] = 1'b0;
    PHASEB_in[3] = 1'b0;
    expect_at(4, "ill03_pre", 2, '1, 32'h0001_0008);
    expect_at(5, "ill03",     2, '1, 32'h0003_0009);
    run(8);

    // Clear in the same cycle a new channel-3 error registers.
    PHASEA_in[3] = 1'b1;
    PHASEB_in[3] = 1'b1;
    expect_at(4, "clrprio_pre", 2, '1, 32'h0003_0009);
    expect_at(5, "clrprio",     2, '1, 32'h0001_0009);
    run(3);
    ERR_CLEAR_Set = 32'h8000_0008;
    run(1);
    ERR_CLEAR_Set = '0;
    run(6);

    // Every channel double-toggles each cycle: count grows by 4 per cycle,
    // saturates at FFFF, then a counter clear reloads with the increment.
    clear_errs();
    expect_at(10,    "sat_early", 2, '1, 32'h0018_000F);
    expect_at(16386, "sat_near",  2, '1, 32'hFFF8_000F);
    expect_at(16388, "sat_hit",   2, '1, 32'hFFFF_000F);
    expect_at(16395, "sat_hold",  2, '1, 32'hFFFF_000F);
    expect_at(16398, "clr_load",  2, '1, 32'h0004_000F);
    expect_at(16399, "clr_next",  2, '1, 32'h0008_000F);
    for (int unsigned k = 1; k <= 16400; k++) begin
      PHASEA_in     = ~PHASEA_in;
      PHASEB_in     = ~PHASEB_in;
      ERR_CLEAR_Set = (k == 16397) ? 32'h8000_0000 : 32'h0;
      run(1);
    end
    ERR_CLEAR_Set = '0;
    run(5);

    checks++;
    assert (sbq.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qei_input_filter.md
Name: qei_input_filter

Overview:
- Front-end conditioning stage that sits directly upstream of the quadrature counter. It takes raw encoder pad signals (phase A/B, CH_NUM channels) and delivers clean, synchronous phases to the counter's phase inputs.
- Per signal: 2-FF synchronizer, then a programmable glitch filter.
- Also detects illegal quadrature transitions (A and B filtered outputs changing in the same cycle). Reports them via sticky flags and a saturating count, readable as a 32-bit register.

Parameters:
- CH_NUM, 4, number of encoder channels (1..16).
- CNT_W, 8, width of the filter threshold and per-signal filter counters.

Ports:
- CLK  input  1  system clock.
- RST_n  input  1  reset, asynchronous, active-low.
- FILT_CFG_Set  input  32  bits [CNT_W-1:0] = filter threshold N; other bits ignored.
- ERR_CLEAR_Set  input  32  bit i (i<CH_NUM) clears error flag i; bit 31 clears the error counter; level-sensitive, acts every cycle it is high.
- PHASEA_in  input  CH_NUM  raw asynchronous phase A, bit i = channel i.
- PHASEB_in  input  CH_NUM  raw asynchronous phase B.
- PHASEA_out  output  CH_NUM  filtered phase A, registered.
- PHASEB_out  output  CH_NUM  filtered phase B, registered.
- ERR_Read  output  32  [CH_NUM-1:0] sticky illegal-transition flags; [31:16] saturating error count; other bits read 0.

Behaviour:
- Reset (async, RST_n low) clears all state to 0: sync FFs, filter counters, PHASEA_out, PHASEB_out, flags, counter, ERR_Read. Release is synchronous to CLK.
- Synchronizer, per signal: s1 <= pad; s2 <= s1. No other use of raw inputs.
- Filter, per signal, with counter cnt (CNT_W bits, reset 0) and output out:
  - s2 == out: cnt <= 0.
  - s2 != out and cnt >= N: out <= s2, cnt <= 0.
  - otherwise: cnt <= cnt+1.
- Latency: a stable pad edge appears on out at clock edge N+3, counted from the first edge that samples it. N=0 gives 3 cycles.
- A level at s2 lasting fewer than N+1 consecutive cycles never reaches out.
- N is read live every cycle. If N is lowered below a running cnt, out updates on the next cycle where s2 != out. cnt never exceeds N+1 in normal operation and never wraps.
- Illegal transition: channel i when PHASEA_out[i] and PHASEB_out[i] both toggle on the same clock edge. Detection is registered; flag/counter update one cycle after the double toggle is visible on the outputs.
- Flag i: set on illegal transition of channel i. Cleared by ERR_CLEAR_Set[i]. Set has priority over clear in the same cycle.
- Counter: increments by the number of channels with an illegal transition in that cycle (0..CH_NUM), saturating at 16'hFFFF.
  - ERR_CLEAR_Set[31] loads the counter with that cycle's increment, not 0, so same-cycle events are not lost.
- ERR_Read is a registered copy of flags/counter; unused bits are 0.
- Filtered outputs are not altered by error detection; the downstream counter ignores double changes.

Test Plan:
- Reset mid-stream: drive pads high, pulse RST_n low 1 ns mid-cycle -> all outputs 0 immediately. After release with pads held high and N=0, PHASEA_out/PHASEB_out go 1 at the 3rd edge.
- Latency: N=5, step PHASEA_in[0] 0->1 and hold -> PHASEA_out[0] rises on edge 8 exactly; other channels unchanged.
- Glitch rejection: N=3, pulse PHASEB_in[2] high for 3 cycles -> PHASEB_out[2] stays 0. A 4-cycle pulse -> PHASEB_out[2] high for 4 cycles, delayed by 6.
- Quadrature pass-through: N=2, feed channel 1 sequence 00->01->11->10->00, 20 cycles per step -> outputs reproduce the sequence with 5-cycle delay; ERR_Read stays 0.
- Illegal transition: N=0, switch channel 3 pads 00->11 simultaneously -> ERR_Read[3]=1 and ERR_Read[31:16]=1. Repeat on channels 0 and 3 together -> count=3.
- Clear priority: assert ERR_CLEAR_Set[3] and ERR_CLEAR_Set[31] in the cycle a new channel-3 error registers -> flag 3 stays 1, count=1. Preload count 16'hFFFF, inject error -> stays 16'hFFFF.
